// File: rtl/fifo_burst_rd_if.sv
// Handshake bundle between the burst reader, the FIFO read port and the downstream sink.
// master = burst reader side; slave = FIFO + sink side.
interface fifo_burst_rd_if #(
  parameter int DW = 8
);
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout;
  logic          empty;
  logic          almost_empty;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output fifo_rd_en, out_data, out_valid,
    input  fifo_dout, empty, almost_empty, out_ready
  );

  modport slave (
    input  fifo_rd_en, out_data, out_valid,
    output fifo_dout, empty, almost_empty, out_ready
  );
endinterface

// File: rtl/fifo_burst_rd.sv
// Read-side burst controller for a dual-clock FIFO: sync almost_full, settle, then burst-read.
// Optional FIFO_BURST_RD_STATS_EN adds saturating words_total / bursts_total counters.
module fifo_burst_rd #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 10,
  parameter int BURST_LEN   = 64,
  parameter int TIMEOUT     = 255,
  localparam int CW         = $clog2(BURST_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic                 almost_full,
  fifo_burst_rd_if.master      bus,
  output logic                 busy,
  output logic [CW-1:0]        burst_cnt,
  output logic                 timeout_err
`ifdef FIFO_BURST_RD_STATS_EN
  ,
  output logic [31:0]          words_total,
  output logic [15:0]          bursts_total
`endif
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int EW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    READ
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] af_sync_q, af_sync_d;
  logic                   armed_q, armed_d;
  logic                   mode_q, mode_d;
  logic [CW-1:0]          burst_cnt_q, burst_cnt_d;
  logic [SW-1:0]          settle_cnt_q, settle_cnt_d;
  logic [EW-1:0]          empty_cnt_q, empty_cnt_d;
  logic                   timeout_err_q, timeout_err_d;
  logic                   out_valid_q, out_valid_d;

  logic                   af_syn;
  logic                   stop;
  logic                   rd_en;
  logic [DW-1:0]          dout_w;

  assign af_syn = af_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d       = state_q;
    af_sync_d     = {af_sync_q[SYNC_STAGES-2:0], almost_full};
    armed_d       = armed_q;
    mode_d        = mode_q;
    burst_cnt_d   = burst_cnt_q;
    settle_cnt_d  = settle_cnt_q;
    empty_cnt_d   = empty_cnt_q;
    timeout_err_d = timeout_err_q;
    rd_en         = 1'b0;
    // Drain mode must stop in the same cycle almost_empty rises, so stop stays combinational.
    stop          = mode_q ? (burst_cnt_q == CW'(BURST_LEN)) : bus.almost_empty;

    if (!af_syn) begin
      armed_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (af_syn && armed_q) begin
          state_d      = SETTLE;
          armed_d      = 1'b0;
          mode_d       = mode;
          burst_cnt_d  = '0;
          settle_cnt_d = '0;
          empty_cnt_d  = '0;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == SW'(SETTLE_CYC - 1)) begin
          state_d = READ;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      READ: begin
        rd_en = bus.out_ready & ~bus.empty & ~stop;
        if (rd_en && (burst_cnt_q != CW'(BURST_LEN))) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
        if (stop) begin
          state_d = IDLE;
        end else if (mode_q) begin
          if (rd_en) begin
            empty_cnt_d = '0;
          end else if (bus.empty) begin
            if (empty_cnt_q == EW'(TIMEOUT - 1)) begin
              state_d       = IDLE;
              timeout_err_d = 1'b1;
            end else begin
              empty_cnt_d = empty_cnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = rd_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      af_sync_q     <= '0;
      armed_q       <= 1'b1;
      mode_q        <= 1'b0;
      burst_cnt_q   <= '0;
      settle_cnt_q  <= '0;
      empty_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      af_sync_q     <= af_sync_d;
      armed_q       <= armed_d;
      mode_q        <= mode_d;
      burst_cnt_q   <= burst_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
      empty_cnt_q   <= empty_cnt_d;
      timeout_err_q <= timeout_err_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign dout_w         = bus.fifo_dout;
  assign bus.out_data   = dout_w;
  assign bus.out_valid  = out_valid_q;
  assign bus.fifo_rd_en = rd_en;
  assign busy           = (state_q != IDLE);
  assign burst_cnt      = burst_cnt_q;
  assign timeout_err    = timeout_err_q;

`ifdef FIFO_BURST_RD_STATS_EN
  logic [31:0] words_total_q, words_total_d;
  logic [15:0] bursts_total_q, bursts_total_d;

  // Timeout aborts leave READ the same way as normal stops, so both are counted.
  always_comb begin
    words_total_d  = words_total_q;
    bursts_total_d = bursts_total_q;
    if (rd_en && (words_total_q != '1)) begin
      words_total_d = words_total_q + 1'b1;
    end
    if ((state_q == READ) && (state_d == IDLE) && (bursts_total_q != '1)) begin
      bursts_total_d = bursts_total_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      words_total_q  <= '0;
      bursts_total_q <= '0;
    end else begin
      words_total_q  <= words_total_d;
      bursts_total_q <= bursts_total_d;
    end
  end

  assign words_total  = words_total_q;
  assign bursts_total = bursts_total_q;
`endif

endmodule
